mips_icache_param: RTL and testbench

MIPS_ICACHE_PARAM -- requirements
Module: mips_icache_param

---
 rtl/mips_cache_pkg.sv | 25 ++
 rtl/mips_plru_tree.sv | 45 ++++
 rtl/mips_icache_param.sv | 199 +++++++++++++++++++
 tb/tb_mips_icache_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cache_pkg.sv
// Shared definitions for the parameterised MIPS instruction cache:
// FSM state encoding, address-split widths and the counter ceiling.
package mips_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned line_words);
    return 32 - idx_bits(sets) - off_bits(line_words) - 2;
  endfunction

endpackage

// File: rtl/mips_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and touch update.
// The root splits on way bit 0, deeper levels on successively higher way bits.
module mips_plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         plru,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [WAYS-2:0]         plru_next,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int unsigned WB = $clog2(WAYS);

  // Each node bit names the way-bit value on the side to evict next.
  always_comb begin : victim_walk
    int node;
    int vic;
    node = 1;
    vic  = 0;
    for (int k = 0; k < int'(WB); k++) begin
      if (plru[WB'(node - 1)]) begin
        vic  = vic | (1 << k);
        node = 2 * node + 1;
      end else begin
        node = 2 * node;
      end
    end
    victim = WB'(vic);
  end

  // Touching a way points every node on its path away from it.
  always_comb begin : touch_walk
    int node;
    int wbit;
    plru_next = plru;
    node      = 1;
    wbit      = 0;
    for (int k = 0; k < int'(WB); k++) begin
      wbit = (int'(touch_way) >> k) & 1;
      plru_next[WB'(node - 1)] = (wbit == 0);
      node = 2 * node + wbit;
    end
  end

endmodule

// File: rtl/mips_icache_param.sv
// Set-associative, read-only instruction cache with tree-PLRU replacement,
// sequential line fill from memory and a one-set-per-cycle flush walk.
module mips_icache_param
  import mips_cache_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read_en,
  output logic [31:0] readdata,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OB  = off_bits(LINE_WORDS);
  localparam int unsigned IB  = idx_bits(SETS);
  localparam int unsigned TB  = tag_bits(SETS, LINE_WORDS);
  localparam int unsigned OBW = (OB > 0) ? OB : 1;
  localparam int unsigned WB  = $clog2(WAYS);

  state_t           state_q, state_d;
  logic [OBW-1:0]   beat_q;
  logic [TB-1:0]    fill_tag_q;
  logic [IB-1:0]    fill_idx_q;
  logic [WB-1:0]    victim_q;
  logic             flush_pend_q;
  logic [IB-1:0]    flush_idx_q;
  logic             retry_q;
  logic [31:0]      hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-2:0]  plru_q   [SETS];
  logic [TB-1:0]    tag_mem  [WAYS][SETS];
  logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];

  logic [TB-1:0]    a_tag;
  logic [IB-1:0]    a_idx;
  logic [OBW-1:0]   a_off;
  logic             hit_any, hit;
  logic [WB-1:0]    hit_way;
  logic             inv_any;
  logic [WB-1:0]    inv_way, new_victim;
  logic [IB-1:0]    plru_set;
  logic [WB-1:0]    plru_touch, plru_victim;
  logic [WAYS-2:0]  plru_next;
  logic             last_beat, fill_beat, fill_done;

  assign a_tag = TB'(addr >> (IB + OB + 2));
  assign a_idx = IB'(addr >> (OB + 2));
  assign a_off = OBW'(addr >> 2) & OBW'(LINE_WORDS - 1);

  // Tag compare across all ways of the addressed set; lowest way wins.
  always_comb begin : hit_detect
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[a_idx][WB'(w)] && (tag_mem[WB'(w)][a_idx] == a_tag)) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // Empty ways are filled before the PLRU victim is consulted.
  always_comb begin : victim_pick
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[a_idx][WB'(w)]) begin
        inv_any = 1'b1;
        inv_way = WB'(w);
      end
    end
  end

  assign new_victim = inv_any ? inv_way : plru_victim;
  assign hit        = (state_q == IDLE) && read_en && hit_any;
  assign readdata   = hit ? data_mem[hit_way][a_idx][a_off] : 32'd0;

  // One PLRU engine: fill-time touches use the latched set, otherwise the CPU set.
  assign plru_set   = (state_q == FILL) ? fill_idx_q : a_idx;
  assign plru_touch = (state_q == FILL) ? victim_q : hit_way;

  mips_plru_tree #(.WAYS(WAYS)) u_plru (
    .plru      (plru_q[plru_set]),
    .touch_way (plru_touch),
    .plru_next (plru_next),
    .victim    (plru_victim)
  );

  assign last_beat = (beat_q == OBW'(LINE_WORDS - 1));
  assign fill_beat = (state_q == FILL) && mem_valid;
  assign fill_done = fill_beat && last_beat;

  always_ff @(posedge clk or negedge rst) begin : state_reg
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    stall    = 1'b1;
    mem_req  = 1'b0;
    mem_addr = 32'd0;
    unique case (state_q)
      IDLE: begin
        stall = read_en && !hit_any;
        if (flush)                     state_d = FLUSH;
        else if (read_en && !hit_any)  state_d = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = (32'(fill_tag_q) << (IB + OB + 2)) |
                   (32'(fill_idx_q) << (OB + 2)) |
                   (32'(beat_q) << 2);
        if (fill_done) state_d = (flush_pend_q || flush) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (flush_idx_q == IB'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, valid/PLRU arrays and counters.
  always_ff @(posedge clk or negedge rst) begin : ctrl_reg
    if (!rst) begin
      beat_q       <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      victim_q     <= '0;
      flush_pend_q <= 1'b0;
      flush_idx_q  <= '0;
      retry_q      <= 1'b0;
      hit_cnt_q    <= 32'd0;
      miss_cnt_q   <= 32'd0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[IB'(s)] <= '0;
        plru_q[IB'(s)]  <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          retry_q <= 1'b0;
          if (flush) begin
            flush_idx_q <= '0;
          end else if (read_en && !hit_any) begin
            fill_tag_q <= a_tag;
            fill_idx_q <= a_idx;
            victim_q   <= new_victim;
            beat_q     <= '0;
            if (miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + 32'd1;
          end
          if (hit) begin
            plru_q[a_idx] <= plru_next;
            if (!retry_q && (hit_cnt_q != CNT_MAX)) hit_cnt_q <= hit_cnt_q + 32'd1;
          end
        end
        FILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (fill_beat) beat_q <= last_beat ? '0 : beat_q + OBW'(1);
          if (fill_done) begin
            valid_q[fill_idx_q][victim_q] <= 1'b1;
            plru_q[fill_idx_q]            <= plru_next;
            retry_q                       <= !(flush_pend_q || flush);
            flush_pend_q                  <= 1'b0;
            flush_idx_q                   <= '0;
          end
        end
        FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          plru_q[flush_idx_q]  <= '0;
          flush_idx_q          <= flush_idx_q + IB'(1);
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin : array_wr
    if (fill_beat) data_mem[victim_q][fill_idx_q][beat_q] <= mem_rdata;
    if (fill_done) tag_mem[victim_q][fill_idx_q] <= fill_tag_q;
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_mips_icache_param.sv
// Self-checking bench for mips_icache_param (4 ways, 8 sets, 4-word lines)
// with a randomly-paced memory responder.
module tb_mips_icache_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read_en;
  logic [31:0] readdata;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  mips_icache_param #(.WAYS(4), .SETS(8), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .read_en    (read_en),
    .readdata   (readdata),
    .stall      (stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    bit          flush_first;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] beat_log[$];
  vec_t        vecs[22];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h0000100) return 32'hA0 + 32'(w[3:2]);
    return w ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input bit h, input bit fl);
    vec_t v;
    v.addr = a;
    v.data = mem_word(a);
    v.hit = h;
    v.flush_first = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers fill beats with random gaps.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req && rst) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_rdata = mem_word(mem_addr);
        if (mem_valid) beat_log.push_back(mem_addr);
      end else begin
        mem_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Starts and ends just after a rising edge.
  task automatic fetch(input vec_t v, input string name);
    int          cyc;
    logic [31:0] exp;
    addr    = v.addr;
    read_en = 1'b1;
    exp_q.push_back(v.data);
    cyc = 0;
    @(negedge clk);
    if (stall) check({name, "_miss_rdata_zero"}, readdata, 32'd0);
    while (stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (stall) check({name, "_timeout"}, 32'(stall), 32'd0);
    exp = exp_q.pop_front();
    check({name, "_rdata"}, readdata, exp);
    check({name, "_zero_stall"}, 32'(cyc == 0), 32'(v.hit));
    if (v.hit) exp_hits++;
    else       exp_misses++;
    @(posedge clk);
    #1;
    read_en = 1'b0;
  endtask

  task automatic do_flush();
    int cnt;
    flush = 1'b1;
    @(negedge clk);
    check("flush_entry_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (stall) cnt++;
    end
    check("flush_stall_cycles", 32'(cnt), 32'd8);
    @(negedge clk);
    check("flush_exit_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gap;
    int cyc;
    bit flush_sent;

    vecs[0]  = mk(32'h1000, 1'b0, 1'b0);
    vecs[1]  = mk(32'h1008, 1'b1, 1'b0);
    vecs[2]  = mk(32'h100C, 1'b1, 1'b0);
    vecs[3]  = mk(32'h2014, 1'b0, 1'b0);
    vecs[4]  = mk(32'h2010, 1'b1, 1'b0);
    vecs[5]  = mk(32'h101C, 1'b0, 1'b0);
    vecs[6]  = mk(32'h2018, 1'b1, 1'b0);
    vecs[7]  = mk(32'h1004, 1'b1, 1'b0);
    vecs[8]  = mk(32'h1000, 1'b0, 1'b1);
    vecs[9]  = mk(32'h0080, 1'b0, 1'b1);
    vecs[10] = mk(32'h0100, 1'b0, 1'b0);
    vecs[11] = mk(32'h0180, 1'b0, 1'b0);
    vecs[12] = mk(32'h0200, 1'b0, 1'b0);
    vecs[13] = mk(32'h0084, 1'b1, 1'b0);
    vecs[14] = mk(32'h0104, 1'b1, 1'b0);
    vecs[15] = mk(32'h0204, 1'b1, 1'b0);
    vecs[16] = mk(32'h0280, 1'b0, 1'b0);
    vecs[17] = mk(32'h0088, 1'b1, 1'b0);
    vecs[18] = mk(32'h0108, 1'b1, 1'b0);
    vecs[19] = mk(32'h0208, 1'b1, 1'b0);
    vecs[20] = mk(32'h0288, 1'b1, 1'b0);
    vecs[21] = mk(32'h0180, 1'b0, 1'b0);

    rst     = 1'b0;
    read_en = 1'b1;
    addr    = 32'h1000;
    flush   = 1'b0;
    #12;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_readdata", readdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    read_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].flush_first) do_flush();
      if (i == 0) beat_log.delete();
      fetch(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("cold_beat_count", 32'(beat_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < beat_log.size(); k++)
          check($sformatf("cold_beat%0d_addr", k), beat_log[k], 32'h1000 + 32'(4 * k));
      end
      check($sformatf("vec%0d_hit_count", i), hit_count, 32'(exp_hits));
      check($sformatf("vec%0d_miss_count", i), miss_count, 32'(exp_misses));
    end

    // Flush raised mid-fill: fill finishes, flush walk follows, line refetched.
    addr       = 32'h1000;
    read_en    = 1'b1;
    gap        = 0;
    cyc        = 0;
    flush_sent = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!stall) break;
      if (!mem_req) gap++;
      if (!flush_sent && mem_req && mem_addr == 32'h1008) begin
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        flush_sent = 1'b1;
      end
    end
    check("fmf_timeout", 32'(stall), 32'd0);
    check("fmf_idle_gap", 32'(gap), 32'd10);
    check("fmf_readdata", readdata, 32'hA0);
    exp_misses += 2;
    @(posedge clk);
    #1;
    read_en = 1'b0;
    check("fmf_miss_count", miss_count, 32'(exp_misses));
    check("fmf_hit_count", hit_count, 32'(exp_hits));
    fetch(mk(32'h100C, 1'b1, 1'b0), "fmf_reuse");
    check("fmf_reuse_hit_count", hit_count, 32'(exp_hits));

    // Reset asserted during beat 1 abandons the fill.
    do_flush();
    addr    = 32'h1000;
    read_en = 1'b1;
    cyc     = 0;
    while (!(mem_req && mem_addr == 32'h1004) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rmf_reach_beat1", mem_addr, 32'h1004);
    rst = 1'b0;
    #1;
    check("rmf_mem_req", 32'(mem_req), 32'd0);
    check("rmf_mem_addr", mem_addr, 32'd0);
    check("rmf_stall", 32'(stall), 32'd1);
    check("rmf_readdata", readdata, 32'd0);
    check("rmf_miss_count", miss_count, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    read_en    = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk);
    #1;
    fetch(mk(32'h1000, 1'b0, 1'b0), "rmf_refetch");
    check("rmf_after_miss_count", miss_count, 32'd1);
    check("rmf_after_hit_count", hit_count, 32'd0);
    fetch(mk(32'h1008, 1'b1, 1'b0), "rmf_reuse");
    check("rmf_reuse_hit_count", hit_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
